// File: rtl/atomik_report_pkg.sv
// Shared constants and types for the latency report frame.
// Frame length depends on LATENCY_REPORTER_CHECKSUM_EN.
package atomik_report_pkg;

    localparam logic [7:0] HDR_BYTE     = 8'hA5;
    localparam logic [7:0] TAG_LOAD     = 8'h4C;
    localparam logic [7:0] TAG_ACC      = 8'h41;
    localparam logic [7:0] TAG_RECON    = 8'h52;
    localparam logic [7:0] TAG_ROLLBACK = 8'h42;

    localparam int unsigned NUM_RECORDS    = 4;
    localparam int unsigned FRAME_LEN_BASE = 13;
    localparam int unsigned FRAME_LEN_CSUM = 14;

`ifdef LATENCY_REPORTER_CHECKSUM_EN
    localparam int unsigned FRAME_LEN = FRAME_LEN_CSUM;
`else
    localparam int unsigned FRAME_LEN = FRAME_LEN_BASE;
`endif

    localparam int unsigned IDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_IDLE = 2'd1,
        ST_SEND      = 2'd2
    } state_e;

    // Snapshot of the four latencies, index 0 = LOAD ... 3 = ROLLBACK.
    typedef logic [NUM_RECORDS-1:0][15:0] snap_t;

endpackage

// File: rtl/report_byte_mux.sv
// Combinational frame byte select: index -> header, tag, latency byte or checksum.
// Checksum byte exists only with LATENCY_REPORTER_CHECKSUM_EN.
module report_byte_mux
    import atomik_report_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    input  snap_t            snap_i,
    output logic [7:0]       byte_o
);

`ifdef LATENCY_REPORTER_CHECKSUM_EN
    logic [7:0] csum;

    always_comb begin
        csum = TAG_LOAD ^ TAG_ACC ^ TAG_RECON ^ TAG_ROLLBACK;
        for (int unsigned r = 0; r < NUM_RECORDS; r++) begin
            csum = csum ^ snap_i[r][15:8] ^ snap_i[r][7:0];
        end
    end
`endif

    always_comb begin
        byte_o = '0;
        case (idx_i)
            4'd0:  byte_o = HDR_BYTE;
            4'd1:  byte_o = TAG_LOAD;
            4'd2:  byte_o = snap_i[0][15:8];
            4'd3:  byte_o = snap_i[0][7:0];
            4'd4:  byte_o = TAG_ACC;
            4'd5:  byte_o = snap_i[1][15:8];
            4'd6:  byte_o = snap_i[1][7:0];
            4'd7:  byte_o = TAG_RECON;
            4'd8:  byte_o = snap_i[2][15:8];
            4'd9:  byte_o = snap_i[2][7:0];
            4'd10: byte_o = TAG_ROLLBACK;
            4'd11: byte_o = snap_i[3][15:8];
            4'd12: byte_o = snap_i[3][7:0];
`ifdef LATENCY_REPORTER_CHECKSUM_EN
            4'd13: byte_o = csum;
`endif
            default: byte_o = '0;
        endcase
    end

endmodule

// File: rtl/latency_reporter.sv
// Snapshots the four latency counters and streams them as a byte frame over valid/ready.
// Optional trailing XOR checksum byte under LATENCY_REPORTER_CHECKSUM_EN.
module latency_reporter
    import atomik_report_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [COUNT_WIDTH-1:0] load_latency,
    input  logic [COUNT_WIDTH-1:0] accumulate_latency,
    input  logic [COUNT_WIDTH-1:0] reconstruct_latency,
    input  logic [COUNT_WIDTH-1:0] rollback_latency,
    input  logic                   measuring,
    input  logic                   report_req,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic [7:0]             frame_count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    snap_t            snap_q, snap_d;
    logic             pending_q, pending_d;
    logic [7:0]       frame_count_q, frame_count_d;
    logic [7:0]       mux_byte;
    logic             start;
    logic             capture;
    logic             xfer;
    logic             last_xfer;

    assign start     = (state_q == ST_IDLE) && (report_req || pending_q);
    assign capture   = (start && !measuring) || ((state_q == ST_WAIT_IDLE) && !measuring);
    assign xfer      = (state_q == ST_SEND) && tx_ready;
    assign last_xfer = xfer && (idx_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            snap_q        <= '0;
            pending_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            snap_q        <= snap_d;
            pending_q     <= pending_d;
            frame_count_q <= frame_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (start) state_d = measuring ? ST_WAIT_IDLE : ST_SEND;
            ST_WAIT_IDLE: if (!measuring) state_d = ST_SEND;
            ST_SEND:      if (last_xfer) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Datapath next-state: a request arriving while busy (including the
    // final-byte cycle) is remembered as a single pending frame.
    always_comb begin
        snap_d        = snap_q;
        idx_d         = idx_q;
        pending_d     = pending_q;
        frame_count_d = frame_count_q;
        if (capture) begin
            snap_d[0] = 16'(load_latency);
            snap_d[1] = 16'(accumulate_latency);
            snap_d[2] = 16'(reconstruct_latency);
            snap_d[3] = 16'(rollback_latency);
            idx_d     = '0;
        end else if (xfer) begin
            idx_d = last_xfer ? '0 : IDX_W'(idx_q + 1'b1);
        end
        if (start) begin
            pending_d = 1'b0;
        end else if (report_req && (state_q != ST_IDLE)) begin
            pending_d = 1'b1;
        end
        if (last_xfer) begin
            frame_count_d = frame_count_q + 8'd1;
        end
    end

    report_byte_mux u_byte_mux (
        .idx_i  (idx_q),
        .snap_i (snap_q),
        .byte_o (mux_byte)
    );

    always_comb begin
        tx_valid    = (state_q == ST_SEND);
        tx_data     = (state_q == ST_SEND) ? mux_byte : '0;
        busy        = (state_q != ST_IDLE);
        frame_count = frame_count_q;
    end

endmodule
